// File: rtl/uart_prog_loader.sv
// Boot loader: pops framed image bytes from the UART data register and writes 32-bit words to imem.
// Define UART_LOADER_CHECKSUM_EN to compare the trailing CSUM byte against the data-byte sum.
module uart_prog_loader #(
    parameter logic [10:0] UDR_ADDR       = 11'h402,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 4096,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rstB,
    input  logic        progEn,
    input  logic        rxFfEmpty,
    output logic [10:0] uartAddr,
    output logic        uartRdEn,
    input  logic [31:0] uartDataOut,
    input  logic        uartOutEn,
    output logic [31:0] imemAddr,
    output logic [31:0] imemWrData,
    output logic        imemWrEn,
    output logic        cpuRstB,
    output logic        loadDone,
    output logic        loadErr
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERROR} state_t;
    typedef enum logic [1:0] {F_REQ, F_WAIT, F_GAP} fetch_t;

    state_t          state, stateNext;
    fetch_t          fetch, fetchNext;
    logic [1:0]      waitCnt;
    logic            stale, staleNext;
    logic [TO_W-1:0] toCnt;
    logic [7:0]      lenLo;
    logic [15:0]     wordCnt, wordIdx, lenNew;
    logic [1:0]      byteIdx;
    logic [23:0]     wordBuf;
    logic [7:0]      rxByte;
    logic            receiving, timing, byteVld, rdTimeout, idleTimeout, csumOk;
    logic            unusedUpper;

    assign rxByte      = uartDataOut[7:0];
    assign unusedUpper = ^uartDataOut[31:8];
    assign lenNew      = {rxByte, lenLo};
    assign receiving   = progEn && (state inside {SYNC, LEN0, LEN1, DATA, CSUM});
    assign timing      = progEn && (state inside {LEN0, LEN1, DATA, CSUM});
    // A read left in flight by an abort is drained as stale so its data never reaches the parser.
    assign byteVld     = receiving && !stale && (fetch == F_WAIT) && uartOutEn;
    assign rdTimeout   = receiving && !stale && (fetch == F_WAIT) && !uartOutEn && (waitCnt == 2'd3);
    assign idleTimeout = timing && rxFfEmpty && (toCnt == TO_W'(TIMEOUT_CYCLES - 1));

    assign uartAddr = UDR_ADDR;
    assign cpuRstB  = (state == IDLE) || (state == DONE);
    assign loadDone = (state == DONE);
    assign loadErr  = (state == ERROR);

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] csumAcc;

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB)                      csumAcc <= '0;
        else if (state == SYNC)         csumAcc <= '0;
        else if (state == DATA && byteVld) csumAcc <= csumAcc + rxByte;
    end

    assign csumOk = (rxByte == csumAcc);
`else
    assign csumOk = 1'b1;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fetchNext = fetch;
        uartRdEn  = 1'b0;
        case (fetch)
            F_REQ:  if (receiving && !rxFfEmpty) begin
                        uartRdEn  = 1'b1;
                        fetchNext = F_WAIT;
                    end
            F_WAIT: if (uartOutEn || waitCnt == 2'd3) fetchNext = F_GAP;
            F_GAP:  fetchNext = F_REQ;
            default: fetchNext = F_REQ;
        endcase
        staleNext = (fetchNext == F_WAIT) && (stale || !progEn);
    end

    always_comb begin
        stateNext = state;
        if (!progEn)                       stateNext = IDLE;
        else if (rdTimeout || idleTimeout) stateNext = ERROR;
        else begin
            case (state)
                IDLE: stateNext = SYNC;
                SYNC: if (byteVld && rxByte == SYNC_BYTE) stateNext = LEN0;
                LEN0: if (byteVld) stateNext = LEN1;
                LEN1: if (byteVld) begin
                          if ({16'd0, lenNew} > 32'(MAX_WORDS)) stateNext = ERROR;
                          else if (lenNew == 16'd0)            stateNext = CSUM;
                          else                                 stateNext = DATA;
                      end
                DATA: if (byteVld && byteIdx == 2'd3 && (wordIdx + 16'd1) == wordCnt) stateNext = CSUM;
                CSUM: if (byteVld) stateNext = csumOk ? DONE : ERROR;
                default: stateNext = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            state      <= IDLE;
            fetch      <= F_REQ;
            stale      <= 1'b0;
            waitCnt    <= '0;
            toCnt      <= '0;
            lenLo      <= '0;
            wordCnt    <= '0;
            wordIdx    <= '0;
            byteIdx    <= '0;
            wordBuf    <= '0;
            imemWrEn   <= 1'b0;
            imemAddr   <= BASE_ADDR;
            imemWrData <= '0;
        end else begin
            state    <= stateNext;
            fetch    <= fetchNext;
            stale    <= staleNext;
            imemWrEn <= 1'b0;
            waitCnt  <= (fetch == F_WAIT) ? waitCnt + 2'd1 : 2'd0;
            toCnt    <= (timing && rxFfEmpty) ? toCnt + 1'b1 : '0;
            if (byteVld) begin
                case (state)
                    LEN0: lenLo <= rxByte;
                    LEN1: begin
                        wordCnt <= lenNew;
                        wordIdx <= '0;
                        byteIdx <= '0;
                    end
                    DATA: begin
                        case (byteIdx)
                            2'd0: wordBuf[7:0]   <= rxByte;
                            2'd1: wordBuf[15:8]  <= rxByte;
                            2'd2: wordBuf[23:16] <= rxByte;
                            default: begin
                                imemWrEn   <= 1'b1;
                                imemWrData <= {rxByte, wordBuf};
                                imemAddr   <= BASE_ADDR + {14'd0, wordIdx, 2'b00};
                                wordIdx    <= wordIdx + 16'd1;
                            end
                        endcase
                        byteIdx <= byteIdx + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: a UART FIFO model feeds frames, a frame-level model predicts writes/outcome.
module tb_uart_prog_loader;
    localparam logic [10:0] UDR   = 11'h402;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          MAXW  = 4096;
    localparam logic [7:0]  SYNCB = 8'hA5;
    localparam int          TO    = 100;

    typedef enum {O_DONE, O_ERR, O_SYNC} outcome_t;
    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rstB, progEn, rxFfEmpty, uartRdEn, uartOutEn, imemWrEn, cpuRstB, loadDone, loadErr;
    logic [10:0] uartAddr;
    logic [31:0] uartDataOut, imemAddr, imemWrData;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [7:0]  rxq[$];
    logic [7:0]  respB[$];
    int          respDue[$];
    int          cyc = 0;
    logic [63:0] expQ[$];

    always #5 clk = ~clk;

    uart_prog_loader #(.UDR_ADDR(UDR), .BASE_ADDR(BASE), .MAX_WORDS(MAXW),
                       .SYNC_BYTE(SYNCB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstB(rstB), .progEn(progEn), .rxFfEmpty(rxFfEmpty),
        .uartAddr(uartAddr), .uartRdEn(uartRdEn), .uartDataOut(uartDataOut),
        .uartOutEn(uartOutEn), .imemAddr(imemAddr), .imemWrData(imemWrData),
        .imemWrEn(imemWrEn), .cpuRstB(cpuRstB), .loadDone(loadDone), .loadErr(loadErr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // UART peripheral model: a pop on each read strobe, data returned two cycles later.
    initial begin : uart_model
        logic        rd;
        logic [31:0] r;
        rxFfEmpty   = 1'b1;
        uartOutEn   = 1'b0;
        uartDataOut = '0;
        forever begin
            @(negedge clk);
            rd = (uartRdEn === 1'b1);
            @(posedge clk);
            #1;
            cyc++;
            if (rd && rstB === 1'b1) begin
                if (rxq.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL read_on_empty: read strobe at cycle %0d, expected none", cyc);
                end else begin
                    respB.push_back(rxq.pop_front());
                    respDue.push_back(cyc + 1);
                end
            end
            if (respDue.size() > 0 && respDue[0] == cyc) begin
                r = $urandom();
                uartOutEn   = 1'b1;
                uartDataOut = {r[23:0], respB.pop_front()};
                void'(respDue.pop_front());
            end else begin
                uartOutEn = 1'b0;
            end
            rxFfEmpty = (rxq.size() == 0);
        end
    end

    // Write monitor: every imem write must match the head of the expected queue.
    initial begin : write_monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rstB === 1'b1 && imemWrEn === 1'b1) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", imemAddr, imemWrData);
                end else begin
                    e = expQ.pop_front();
                    check("wr_addr", imemAddr, e[63:32]);
                    check("wr_data", imemWrData, e[31:0]);
                end
            end
        end
    end

    // Frame-level reference: scan for sync, read length, cut words, compare checksum.
    task automatic predict(input byte_q_t b, output outcome_t oc);
        int         i;
        int         n;
        logic [7:0] sum;
        i   = 0;
        sum = 8'd0;
        while (i < b.size() && b[i] != SYNCB) i++;
        if (i >= b.size()) begin
            oc = O_SYNC;
            return;
        end
        i++;
        if (i + 2 > b.size()) begin
            oc = O_ERR;
            return;
        end
        n = int'(b[i]) + 256 * int'(b[i+1]);
        i += 2;
        if (n > MAXW) begin
            oc = O_ERR;
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (i + 4 > b.size()) begin
                oc = O_ERR;
                return;
            end
            expQ.push_back({BASE + 32'(4 * w), b[i+3], b[i+2], b[i+1], b[i]});
            sum = sum + b[i] + b[i+1] + b[i+2] + b[i+3];
            i += 4;
        end
        if (i >= b.size()) begin
            oc = O_ERR;
            return;
        end
`ifdef UART_LOADER_CHECKSUM_EN
        oc = (b[i] == sum) ? O_DONE : O_ERR;
`else
        oc = O_DONE;
`endif
    endtask

    task automatic runLoad(input string tag, input byte_q_t b, input int gapMax);
        outcome_t oc;
        int       waited;
        predict(b, oc);
        progEn = 1'b1;
        tick(2);
        @(negedge clk);
        check({tag, "_cpu_held"}, cpuRstB, 1'b0);
        tick(1);
        foreach (b[i]) begin
            rxq.push_back(b[i]);
            tick($urandom_range(0, gapMax));
        end
        waited = 0;
        while (loadDone !== 1'b1 && loadErr !== 1'b1 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_finished"}, (loadDone === 1'b1 || loadErr === 1'b1), 1'b1);
        @(negedge clk);
        check({tag, "_done"}, loadDone, (oc == O_DONE));
        check({tag, "_err"}, loadErr, (oc == O_ERR));
        check({tag, "_cpuRstB"}, cpuRstB, (oc == O_DONE));
        check({tag, "_writes_left"}, expQ.size(), 0);
    endtask

    task automatic dropProg(input string tag);
        progEn = 1'b0;
        tick(1);
        @(negedge clk);
        check({tag, "_idle_cpuRstB"}, cpuRstB, 1'b1);
        check({tag, "_idle_flags"}, {loadDone, loadErr}, 2'b00);
        rxq.delete();
        expQ.delete();
        tick(2);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        byte_q_t    fr, fr2;
        outcome_t   oc;
        int         k, n;
        logic [7:0] sum, v;

        rstB   = 1'b0;
        progEn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_uartRdEn", uartRdEn, 1'b0);
        check("rst_uartAddr", uartAddr, UDR);
        check("rst_imemWrEn", imemWrEn, 1'b0);
        check("rst_imemAddr", imemAddr, BASE);
        check("rst_imemWrData", imemWrData, 32'h0);
        check("rst_cpuRstB", cpuRstB, 1'b1);
        check("rst_loadDone", loadDone, 1'b0);
        check("rst_loadErr", loadErr, 1'b0);
        rstB = 1'b1;
        tick(2);

        fr = {8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hE2};
        runLoad("full", fr, 0);
        dropProg("full");

        fr2 = {8'h00, 8'hFF, 8'h5A, fr};
        runLoad("garbage", fr2, 2);
        dropProg("garbage");

        fr2 = fr;
        fr2[11] = 8'hE3;
        runLoad("badcsum", fr2, 0);
        dropProg("badcsum");

        fr2 = {8'hA5, 8'h01, 8'h10};
        runLoad("length", fr2, 0);
        dropProg("length");

        // Timeout: count empty-FIFO cycles from the last pop until loadErr.
        fr2 = {8'hA5, 8'h01, 8'h00, 8'h44};
        predict(fr2, oc);
        progEn = 1'b1;
        foreach (fr2[i]) rxq.push_back(fr2[i]);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(rxq.size() == 0 && rxFfEmpty === 1'b1) && k < 200);
        k = 0;
        while (loadErr !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", k, TO);
        check("timeout_err", loadErr, (oc == O_ERR));
        dropProg("timeout");

        // Abort after 5 data bytes, then restart.
        fr2 = {8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        predict(fr2, oc);
        progEn = 1'b1;
        foreach (fr2[i]) rxq.push_back(fr2[i]);
        k = 0;
        while ((rxq.size() != 0 || expQ.size() != 0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("abort_first_word", expQ.size(), 0);
        tick(6);
        progEn = 1'b0;
        tick(1);
        @(negedge clk);
        check("abort_cpuRstB", cpuRstB, 1'b1);
        check("abort_flags", {loadDone, loadErr}, 2'b00);
        rxq.push_back(8'h06);
        rxq.push_back(8'h07);
        rxq.push_back(8'h08);
        rxq.push_back(8'h24);
        tick(10);
        check("abort_no_reads", rxq.size(), 4);
        progEn = 1'b1;
        tick(2);
        @(negedge clk);
        check("abort_restart_sync", cpuRstB, 1'b0);
        runLoad("restart", fr, 1);
        dropProg("restart");

        // Asynchronous reset in the middle of a load.
        predict(fr, oc);
        progEn = 1'b1;
        foreach (fr[i]) rxq.push_back(fr[i]);
        k = 0;
        while (expQ.size() != 1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("midrst_one_write", expQ.size(), 1);
        #2 rstB = 1'b0;
        #1;
        check("midrst_imemWrEn", imemWrEn, 1'b0);
        check("midrst_imemAddr", imemAddr, BASE);
        check("midrst_imemWrData", imemWrData, 32'h0);
        check("midrst_cpuRstB", cpuRstB, 1'b1);
        check("midrst_uartRdEn", uartRdEn, 1'b0);
        rxq.delete();
        expQ.delete();
        respB.delete();
        respDue.delete();
        progEn = 1'b0;
        @(negedge clk);
        rstB = 1'b1;
        tick(2);

        // Randomized frames: garbage prefix, random payload, occasional bad checksum.
        for (int it = 0; it < 6; it++) begin
            fr2.delete();
            repeat ($urandom_range(0, 3)) begin
                v = 8'($urandom_range(0, 255));
                fr2.push_back((v == SYNCB) ? 8'h00 : v);
            end
            n = $urandom_range(0, 5);
            fr2.push_back(SYNCB);
            fr2.push_back(8'(n));
            fr2.push_back(8'h00);
            sum = 8'h00;
            repeat (4 * n) begin
                v = 8'($urandom_range(0, 255));
                sum = sum + v;
                fr2.push_back(v);
            end
            if ($urandom_range(0, 3) == 0) sum = sum ^ 8'h5C;
            fr2.push_back(sum);
            runLoad($sformatf("rand%0d", it), fr2, 4);
            dropProg($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule
